seg_display_ctrl: RTL
=====================

# seg_display_ctrl

Sequencing controller for the calculator's 4-digit seven-segment output. Accepts a 16-bit binary result on a load strobe and runs a multi-cycle shift-add-3 (double-dabble) conversion, one iteration per clock. It commits the four BCD digits to a display register and time-multiplexes them onto a common-anode display with leading-zero blanking. It also shows overflow (values above 9999) as four dashes. It sits between the CPU result register and the board display pins.

## Interface
- REFRESH_DIV, 100000: clock cycles each digit is driven before the scan advances; minimum 2.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- value_i  in  16  unsigned binary value to display.
- load_i  in  1  single-cycle strobe; samples value_i when accepted.
- busy_o  out  1  conversion in progress.
- done_o  out  1  one-cycle pulse; new digits are committed.
- an_o  out  4  digit enables, active-low, one-hot; bit 0 = ones digit.
- seg_o  out  7  segments {g,f,e,d,c,b,a}, active-low.

## Operation
- FSM states:
  - IDLE: load_i=1 → CONVERT. Latch value_i into the shifter low half, clear the BCD half and the iteration counter, and latch ovf = (value_i > 9999).
  - CONVERT: each cycle, add 3 to every BCD nibble ≥5, then shift left the whole 32-bit shifter by 1. After 16 iterations → DONE.
  - DONE: load_i=1 → CONVERT (same latch actions as in IDLE); otherwise → IDLE.
- load_i during CONVERT is ignored. No queueing.
- Commit: on the edge performing iteration 16, the post-shift BCD nibbles and ovf are written to the display register. The display shows old digits until then.
- Scan:
  - The refresh counter counts 0..REFRESH_DIV-1.
  - On wrap, the digit index increments 0→1→2→3→0.
  - The scan runs continuously, independent of the FSM.
- an_o and seg_o are combinational from the digit index and display register.
  - an_o = ~(1<<idx).
- Blanking: digit k>0 is blank (seg_o=7'h7F) when it and all higher digits are zero. The ones digit is never blanked.
- Overflow: when committed ovf=1, every digit shows a dash (seg_o=7'b0111111). The digit values are don't-care.
- Digit codes, 0-9, standard active-low: 0=7'b1000000, 1=7'b1111001, 4=7'b0011001, 7=7'b1111000, 8=7'b0000000.

## Timing
- Load sampled at edge E0.
- busy_o is high from after E0 until after E16 (16 cycles).
- done_o is high for the single cycle after E16. The display register is already updated in that cycle.
- Load-to-done latency: 16 cycles. Minimum load-to-load spacing: 17 cycles (reload in DONE is accepted).
- Values 0..65535 are accepted. Values >9999 produce garbage BCD internally, but only dashes are displayed.
- Reset (async, any state, including mid-CONVERT):
  - state=IDLE, busy_o=0, done_o=0, shifter=0, iteration counter=0.
  - Display register = 0, ovf=0, refresh counter=0, idx=0.
  - Outputs therefore show "0" on digit 0: an_o=4'b1110, seg_o=7'b1000000.
  - An aborted conversion never commits.
- Digit advance: idx changes on the edge where the refresh counter wraps from REFRESH_DIV-1 to 0.

## Structure
- Package seg_pkg holds:
  - FSM state enum.
  - Segment constants: SEG_BLANK=7'h7F, SEG_DASH=7'b0111111, digit code table.
  - BCD_DIGITS=4, ITERATIONS=16.
- Sub-module seg7_decode: inputs 4-bit BCD, blank, dash; output 7-bit active-low segments. Purely combinational, instantiated once after the digit mux.

## Test plan
- Reset released, REFRESH_DIV=4: an_o=1110, seg_o=1000000 on idx 0; digits 1-3 blank. Scan steps every 4 cycles.
- Load 1234 → busy_o high 16 cycles, done_o pulse at cycle 17. Scan shows segments for 4,3,2,1 on an_o 1110,1101,1011,0111.
- Load 7 → ones shows 7'b1111000; digits 1-3 blank. Load 1000 → zeros in digits 0-2 are displayed, not blanked.
- Load 10000 and 65535 → all four digits show 7'b0111111. Load 9999 → four 9s.
- Load 4321, then assert load_i with 8888 at cycle 5 → 8888 is ignored; 4321 is committed. Load 8888 during DONE → accepted; 8888 is committed 16 cycles later.
- Commit 55, then load 1234 and assert rst at cycle 8 → outputs return to reset values immediately, done_o never pulses, the display shows "0".

Source files
------------

// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment display controller:
// FSM state encoding, segment codes and the double-dabble step helper.
package seg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  localparam int BCD_DIGITS = 4;
  localparam int ITERATIONS = 16;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;

  // Digit code table; non-decimal nibbles render as blank
  function automatic logic [6:0] seg_code(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // One shift-add-3 iteration over the {bcd[15:0], bin[15:0]} shifter:
  // correct every BCD nibble >= 5, then shift the whole word left by one.
  function automatic logic [31:0] dabble_step(input logic [31:0] s);
    logic [31:0] t;
    t = s;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (t[16+4*i +: 4] >= 4'd5) begin
        t[16+4*i +: 4] = t[16+4*i +: 4] + 4'd3;
      end
    end
    return {t[30:0], 1'b0};
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD-to-seven-segment decoder (active-low) with dash and
// blank overrides. Dash wins over blank so overflow shows on every digit.
module seg7_decode
  import seg_pkg::*;
(
  input  logic [3:0] bcd_i,
  input  logic       blank_i,
  input  logic       dash_i,
  output logic [6:0] seg_o
);

  // Select override pattern or table lookup
  always_comb begin
    seg_o = seg_code(bcd_i);
    if (dash_i) begin
      seg_o = SEG_DASH;
    end else if (blank_i) begin
      seg_o = SEG_BLANK;
    end
  end

endmodule

// File: rtl/seg_display_ctrl.sv
// Four-digit seven-segment controller: converts a 16-bit binary value to
// BCD by double-dabble (one iteration per clock), commits the digits to a
// display register and scans them onto a common-anode display with
// leading-zero blanking and overflow dashes.
//
// Handshake: load_i is a single-cycle strobe, accepted only in IDLE or DONE
// (value_i sampled on that edge); it is silently dropped while busy_o is
// high. done_o pulses for exactly the one cycle after the final iteration,
// and the display register already holds the new digits in that cycle.
module seg_display_ctrl
  import seg_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value_i,
  input  logic        load_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [3:0]  an_o,
  output logic [6:0]  seg_o
);

  localparam int CNT_W  = $clog2(REFRESH_DIV);
  localparam int ITER_W = $clog2(ITERATIONS + 1);
  localparam logic [CNT_W-1:0]  REF_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(ITERATIONS - 1);

  state_t              r_state;
  logic                r_busy;
  logic                r_done;
  logic [31:0]         r_shift;
  logic [ITER_W-1:0]   r_iter;
  logic                r_ovf;
  logic [15:0]         r_disp;
  logic                r_disp_ovf;
  logic [CNT_W-1:0]    r_refresh;
  logic [1:0]          r_idx;

  logic [31:0]         w_shift_next;
  logic [3:0]          w_digit;
  logic                w_blank;
  logic [3:0]          w_an;

  assign w_shift_next = dabble_step(r_shift);

  // Conversion FSM; also owns the committed display register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_shift    <= 32'd0;
      r_iter     <= '0;
      r_ovf      <= 1'b0;
      r_disp     <= 16'd0;
      r_disp_ovf <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          r_done <= 1'b0;
          if (load_i) begin
            r_state <= ST_CONVERT;
            r_busy  <= 1'b1;
            r_shift <= {16'd0, value_i};
            r_iter  <= '0;
            r_ovf   <= (value_i > 16'd9999);
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_CONVERT: begin
          r_shift <= w_shift_next;
          r_iter  <= r_iter + 1'b1;
          if (r_iter == ITER_LAST) begin
            r_state    <= ST_DONE;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_disp     <= w_shift_next[31:16];
            r_disp_ovf <= r_ovf;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  // Free-running scan: advance the digit index each time the divider wraps
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_refresh <= '0;
      r_idx     <= 2'd0;
    end else if (r_refresh == REF_LAST) begin
      r_refresh <= '0;
      r_idx     <= r_idx + 2'd1;
    end else begin
      r_refresh <= r_refresh + 1'b1;
    end
  end

  // Digit mux, leading-zero blank detect and anode select
  always_comb begin
    w_digit = r_disp[3:0];
    w_blank = 1'b0;
    case (r_idx)
      2'd0: begin
        w_digit = r_disp[3:0];
        w_blank = 1'b0;
      end
      2'd1: begin
        w_digit = r_disp[7:4];
        w_blank = (r_disp[15:4] == 12'd0);
      end
      2'd2: begin
        w_digit = r_disp[11:8];
        w_blank = (r_disp[15:8] == 8'd0);
      end
      default: begin
        w_digit = r_disp[15:12];
        w_blank = (r_disp[15:12] == 4'd0);
      end
    endcase
    w_an = ~(4'b0001 << r_idx);
  end

  seg7_decode u_decode (
    .bcd_i   (w_digit),
    .blank_i (w_blank),
    .dash_i  (r_disp_ovf),
    .seg_o   (seg_o)
  );

  assign busy_o = r_busy;
  assign done_o = r_done;
  assign an_o   = w_an;

endmodule
